apb_sram_slave: RTL and testbench

APB completer (slave) that answers the transfers driven by the testbench's APB initiator interface. It fronts a word-addressed on-chip SRAM and inserts a fixed, parameterised number of wait states using PREADY. It flags out-of-range and malformed transfers on PSLVERR. It is the DUT end of the bus in the APB SRAM environment.

---
 rtl/apb_sram_if.sv | 34 +++
 rtl/apb_sram_slave.sv | 138 +++++++++++++
 tb/tb_apb_sram_slave.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_sram_if.sv
// APB bus bundle between the initiator and the SRAM completer.
// PSTRB exists only when APB_SRAM_PSTRB_EN is defined.
interface apb_sram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SRAM_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SRAM_PSTRB_EN
    output PSTRB,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SRAM_PSTRB_EN
    input  PSTRB,
`endif
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_sram_slave.sv
// APB completer in front of a word-addressed SRAM with fixed wait states.
// Define APB_SRAM_PSTRB_EN to add byte-lane write strobes (PSTRB).
module apb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 200,
  parameter int WAIT_STATES = 1
) (
  input  logic       PCLK,
  input  logic       PRESET,
  apb_sram_if.slave  bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int MIDX   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic                  err;
    logic [DATA_WIDTH-1:0] wdata;
`ifdef APB_SRAM_PSTRB_EN
    logic [NBYTES-1:0]     strb;
`endif
  } req_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  commit;
  logic                  setup_err;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign setup_err = (32'(bus.PADDR) >= MEM_DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          req_d.addr  = bus.PADDR;
          req_d.write = bus.PWRITE;
          req_d.err   = setup_err;
          req_d.wdata = bus.PWDATA;
`ifdef APB_SRAM_PSTRB_EN
          req_d.strb  = bus.PSTRB;
`endif
          if (WAIT_STATES == 0) begin
            // zero wait states: read the array straight off the setup-phase address
            state_d   = S_READY;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (!bus.PWRITE && !setup_err) ? mem[bus.PADDR[MIDX-1:0]] : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else if (bus.PSEL && bus.PENABLE) begin
          // access phase with no setup: answer with an error, never touch the SRAM
          req_d.write = 1'b0;
          req_d.err   = 1'b1;
          state_d     = S_READY;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
          prdata_d    = '0;
        end
      end
      S_WAIT: begin
        if (!bus.PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_READY;
          pready_d  = 1'b1;
          pslverr_d = req_q.err;
          prdata_d  = (!req_q.write && !req_q.err) ? mem[req_q.addr[MIDX-1:0]] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        if (!bus.PSEL || bus.PENABLE) begin
          commit    = bus.PSEL && req_q.write && !req_q.err;
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // SRAM contents survive reset; reset forces IDLE so commit cannot fire
  always_ff @(posedge PCLK) begin
    if (commit) begin
`ifdef APB_SRAM_PSTRB_EN
      for (int b = 0; b < NBYTES; b++)
        if (req_q.strb[b]) mem[req_q.addr[MIDX-1:0]][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
`else
      mem[req_q.addr[MIDX-1:0]] <= req_q.wdata;
`endif
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_sram_slave.sv
// Randomized self-checking bench for apb_sram_slave against an array model of the SRAM.
module tb_apb_sram_slave;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int WS    = 1;
  localparam int NB    = DW / 8;
`ifdef APB_SRAM_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_sram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [256];

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] st);
    if (int'(a) < DEPTH)
      for (int b = 0; b < NB; b++)
        if (!STRB_EN || st[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // One APB transfer starting #1 after an edge; leaves the bus idle #1 after the completing edge.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] st, output logic [DW-1:0] rd, output logic err,
                          output int waits, output logic rdy_after);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
`ifdef APB_SRAM_PSTRB_EN
    bus.PSTRB = st;
`endif
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    // access-phase bus values must be ignored
    bus.PADDR = AW'($urandom); bus.PWDATA = $urandom; bus.PWRITE = 1'($urandom);
`ifdef APB_SRAM_PSTRB_EN
    bus.PSTRB = NB'($urandom);
`endif
    waits = 0;
    while (bus.PREADY !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge PCLK); #1;
    end
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    @(posedge PCLK); #1;
    rdy_after   = bus.PREADY;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
`ifdef APB_SRAM_PSTRB_EN
    bus.PSTRB = '1;
`endif
    repeat (3) @(posedge PCLK);
    #1;
    n_cmp++; if (bus.PREADY !== 1'b0)  begin n_fail++; $display("FAIL reset_pready got %b want 0", bus.PREADY); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", bus.PSLVERR); end
    n_cmp++; if (bus.PRDATA !== '0)    begin n_fail++; $display("FAIL reset_prdata got %h want 0", bus.PRDATA); end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_cmp++; if (bus.PREADY !== 1'b0)  begin n_fail++; $display("FAIL idle_pready got %b want 0", bus.PREADY); end
  endtask

  task automatic fill_mem;
    logic [DW-1:0] rd; logic err, ra; int w;
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] d;
      d = $urandom;
      apb_xfer(1'b1, AW'(a), d, '1, rd, err, w, ra);
      model_write(AW'(a), d, '1);
    end
  endtask

  task automatic test_basic;
    logic [DW-1:0] rd; logic err, ra; int w;
    apb_xfer(1'b1, 8'h05, 32'hDEADBEEF, '1, rd, err, w, ra);
    model_write(8'h05, 32'hDEADBEEF, '1);
    n_cmp++; if (w !== WS)    begin n_fail++; $display("FAIL basic_wr_waits got %0d want %0d", w, WS); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err got %b want 0", err); end
    apb_xfer(1'b0, 8'h05, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (w !== WS)    begin n_fail++; $display("FAIL basic_rd_waits got %0d want %0d", w, WS); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err got %b want 0", err); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
    n_cmp++; if (ra !== 1'b0)  begin n_fail++; $display("FAIL basic_pready_after got %b want 0", ra); end
  endtask

  task automatic test_out_of_range;
    logic [DW-1:0] rd; logic err, ra; int w;
    apb_xfer(1'b1, 8'hC8, 32'h12345678, '1, rd, err, w, ra);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %b want 1", err); end
    apb_xfer(1'b1, 8'hFF, 32'h87654321, '1, rd, err, w, ra);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ff_err got %b want 1", err); end
    apb_xfer(1'b0, 8'hC8, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err got %b want 1", err); end
    n_cmp++; if (rd !== '0)    begin n_fail++; $display("FAIL oor_rd_data got %h want 0", rd); end
    n_cmp++; if (w !== WS)     begin n_fail++; $display("FAIL oor_rd_waits got %0d want %0d", w, WS); end
    apb_xfer(1'b0, 8'h00, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_addr0_err got %b want 0", err); end
    n_cmp++; if (rd !== ref_mem[0]) begin n_fail++; $display("FAIL oor_addr0_data got %h want %h", rd, ref_mem[0]); end
    apb_xfer(1'b0, 8'hC7, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_addr_err got %b want 0", err); end
    n_cmp++; if (rd !== ref_mem[199]) begin n_fail++; $display("FAIL last_addr_data got %h want %h", rd, ref_mem[199]); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] rd0, rd1, rd2, rd3; logic e0, e1, e2, e3, a0, a1, a2, a3; int w0, w1, w2, w3;
    apb_xfer(1'b1, 8'h10, 32'hA5A5A5A5, '1, rd0, e0, w0, a0);
    apb_xfer(1'b1, 8'h11, 32'h5A5A5A5A, '1, rd1, e1, w1, a1);
    apb_xfer(1'b0, 8'h10, 32'h0, '1, rd2, e2, w2, a2);
    apb_xfer(1'b0, 8'h11, 32'h0, '1, rd3, e3, w3, a3);
    model_write(8'h10, 32'hA5A5A5A5, '1);
    model_write(8'h11, 32'h5A5A5A5A, '1);
    n_cmp++; if (rd2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_rd10 got %h want a5a5a5a5", rd2); end
    n_cmp++; if (rd3 !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL b2b_rd11 got %h want 5a5a5a5a", rd3); end
    n_cmp++; if ({w0, w1, w2, w3} !== {WS, WS, WS, WS}) begin n_fail++; $display("FAIL b2b_waits got %0d %0d %0d %0d want %0d", w0, w1, w2, w3, WS); end
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0) begin n_fail++; $display("FAIL b2b_single_pulse got %b want 0000", {a0, a1, a2, a3}); end
    n_cmp++; if ({e0, e1, e2, e3} !== 4'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0000", {e0, e1, e2, e3}); end
  endtask

  task automatic test_protocol_error;
    logic [DW-1:0] rd; logic err, ra; int w;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h20; bus.PWDATA = 32'hCAFEF00D;
    @(posedge PCLK); #1;
    n_cmp++; if (bus.PREADY !== 1'b1)  begin n_fail++; $display("FAIL proto_pready got %b want 1", bus.PREADY); end
    n_cmp++; if (bus.PSLVERR !== 1'b1) begin n_fail++; $display("FAIL proto_pslverr got %b want 1", bus.PSLVERR); end
    n_cmp++; if (bus.PRDATA !== '0)    begin n_fail++; $display("FAIL proto_prdata got %h want 0", bus.PRDATA); end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    n_cmp++; if (bus.PREADY !== 1'b0)  begin n_fail++; $display("FAIL proto_pready_after got %b want 0", bus.PREADY); end
    apb_xfer(1'b0, 8'h20, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (rd !== ref_mem[8'h20]) begin n_fail++; $display("FAIL proto_mem_kept got %h want %h", rd, ref_mem[8'h20]); end
  endtask

  task automatic test_reset_abort;
    logic [DW-1:0] rd; logic err, ra; int w;
    // reset while the write sits in its wait state
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h30; bus.PWDATA = 32'hFFFFFFFF;
`ifdef APB_SRAM_PSTRB_EN
    bus.PSTRB = '1;
`endif
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    n_cmp++; if ({bus.PREADY, bus.PSLVERR} !== 2'b00) begin n_fail++; $display("FAIL rst_wait_outs got %b want 00", {bus.PREADY, bus.PSLVERR}); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    apb_xfer(1'b0, 8'h30, 32'h0, '1, rd, err, w, ra);
    n_cmp++; if (rd !== ref_mem[8'h30]) begin n_fail++; $display("FAIL rst_mem_kept got %h want %h", rd, ref_mem[8'h30]); end
    // reset while a read is presenting data
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h30;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    n_cmp++; if (bus.PRDATA !== ref_mem[8'h30]) begin n_fail++; $display("FAIL rst_ready_data got %h want %h", bus.PRDATA, ref_mem[8'h30]); end
    #2 PRESET = 1'b1;
    #1;
    n_cmp++; if ({bus.PREADY, bus.PSLVERR} !== 2'b00) begin n_fail++; $display("FAIL rst_ready_outs got %b want 00", {bus.PREADY, bus.PSLVERR}); end
    n_cmp++; if (bus.PRDATA !== '0) begin n_fail++; $display("FAIL rst_ready_prdata got %h want 0", bus.PRDATA); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

`ifdef APB_SRAM_PSTRB_EN
  task automatic test_pstrb;
    logic [DW-1:0] rd; logic err, ra; int w;
    apb_xfer(1'b1, 8'h40, 32'h11223344, 4'b1111, rd, err, w, ra);
    apb_xfer(1'b1, 8'h40, 32'hAABBCCDD, 4'b0101, rd, err, w, ra);
    apb_xfer(1'b0, 8'h40, 32'h0, 4'b0000, rd, err, w, ra);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL pstrb_merge got %h want 11bb33dd", rd); end
    apb_xfer(1'b1, 8'h40, 32'h00000000, 4'b0000, rd, err, w, ra);
    n_cmp++; if (err !== 1'b0 || w !== WS) begin n_fail++; $display("FAIL pstrb_zero_xfer got err=%b waits=%0d want 0/%0d", err, w, WS); end
    apb_xfer(1'b0, 8'h40, 32'h0, 4'b0000, rd, err, w, ra);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL pstrb_zero_nochange got %h want 11bb33dd", rd); end
    model_write(8'h40, 32'h11BB33DD, '1);
  endtask
`endif

  task automatic test_random;
    logic [DW-1:0] rd, d, exp_rd; logic err, ra, wr, exp_err; logic [AW-1:0] a; logic [NB-1:0] st; int w;
    for (int i = 0; i < 120; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, DEPTH - 1));
      wr = 1'($urandom); d = $urandom; st = NB'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge PCLK); #1; end
      apb_xfer(wr, a, d, st, rd, err, w, ra);
      exp_err = (int'(a) >= DEPTH);
      exp_rd  = (!wr && !exp_err) ? ref_mem[a] : '0;
      if (wr && !exp_err) model_write(a, d, st);
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d] a=%h got %b want %b", i, a, err, exp_err); end
      n_cmp++; if (rd !== exp_rd)   begin n_fail++; $display("FAIL rnd_data[%0d] a=%h got %h want %h", i, a, rd, exp_rd); end
      n_cmp++; if (w !== WS || ra !== 1'b0) begin n_fail++; $display("FAIL rnd_timing[%0d] got waits=%0d after=%b want %0d/0", i, w, ra, WS); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    fill_mem();
    test_basic();
    test_out_of_range();
    test_back_to_back();
    test_protocol_error();
    test_reset_abort();
`ifdef APB_SRAM_PSTRB_EN
    test_pstrb();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
